// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and requester IDs for the regfile writeback arbiter
package regfile_pkg;

  localparam int WORD_WIDTH_DEF = 16;
  localparam int IDX_WIDTH_DEF  = 4;
  localparam int NUM_REGS       = 2 ** IDX_WIDTH_DEF;

  localparam int REQ_ALU   = 0;
  localparam int REQ_LOAD  = 1;
  localparam int REQ_DEBUG = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - round-robin arbiter, search starts one past the last winner
module rr_arbiter #(
  parameter int N = 3,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    grant   = '0;
    win_idx = rr_ptr_q;
    cand    = '0;
    found   = 1'b0;
    for (int off = 1; off <= N; off++) begin
      cand = PTR_W'((int'(rr_ptr_q) + off) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        win_idx     = cand;
      end
    end
    rr_ptr_d = (advance && found) ? win_idx : rr_ptr_q;
  end

  // Reset to the last requester so requester 0 is searched first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= PTR_W'(N - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register file write port among writeback requesters
// Pending-write scoreboard is built only with RF_ARB_SCOREBOARD_EN defined.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int IDX_WIDTH  = IDX_WIDTH_DEF,
  parameter int NUM_REQ    = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*IDX_WIDTH-1:0]  req_idx,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_write,
  output logic [IDX_WIDTH-1:0]          out_dst_idx,
  output logic [WORD_WIDTH-1:0]         out_dst,
  input  logic                          reserve_valid,
  input  logic [IDX_WIDTH-1:0]          reserve_idx,
  output logic                          reserve_ready,
  input  logic [IDX_WIDTH-1:0]          chk_src1_idx,
  input  logic [IDX_WIDTH-1:0]          chk_src2_idx,
  output logic                          src1_busy,
  output logic                          src2_busy
);

  localparam int NREGS = 2 ** IDX_WIDTH;

  logic                  transfer;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic [WORD_WIDTH-1:0] sel_data;
  logic                  out_write_q, out_write_d;
  logic [IDX_WIDTH-1:0]  out_dst_idx_q, out_dst_idx_d;
  logic [WORD_WIDTH-1:0] out_dst_q, out_dst_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req_valid),
    .advance (transfer),
    .grant   (req_ready)
  );

  // Writes to index 0 are accepted but never reach the register file.
  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_idx  = req_idx[i*IDX_WIDTH +: IDX_WIDTH];
        sel_data = req_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    transfer      = |(req_valid & req_ready);
    out_write_d   = transfer && (sel_idx != '0);
    out_dst_idx_d = out_write_d ? sel_idx : out_dst_idx_q;
    out_dst_d     = out_write_d ? sel_data : out_dst_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_write_q   <= 1'b0;
      out_dst_idx_q <= '0;
      out_dst_q     <= '0;
    end else begin
      out_write_q   <= out_write_d;
      out_dst_idx_q <= out_dst_idx_d;
      out_dst_q     <= out_dst_d;
    end
  end

  assign out_write   = out_write_q;
  assign out_dst_idx = out_dst_idx_q;
  assign out_dst     = out_dst_q;

`ifdef RF_ARB_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d;

  // Clear on the register file's write edge; a same-edge reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (out_write_q) begin
      busy_d[out_dst_idx_q] = 1'b0;
    end
    if (reserve_valid && reserve_ready && (reserve_idx != '0)) begin
      busy_d[reserve_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign reserve_ready = ~busy_q[reserve_idx];
  assign src1_busy     = busy_q[chk_src1_idx];
  assign src2_busy     = busy_q[chk_src2_idx];
`else
  logic unused_sb;
  assign unused_sb     = ^{reserve_valid, reserve_idx, chk_src1_idx, chk_src2_idx};
  assign reserve_ready = 1'b1;
  assign src1_busy     = 1'b0;
  assign src2_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
// Scoreboard expectations follow RF_ARB_SCOREBOARD_EN when it is defined.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req_valid;
  logic [11:0] req_idx;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        out_write;
  logic [3:0]  out_dst_idx;
  logic [15:0] out_dst;
  logic        reserve_valid;
  logic [3:0]  reserve_idx;
  logic        reserve_ready;
  logic [3:0]  chk_src1_idx;
  logic [3:0]  chk_src2_idx;
  logic        src1_busy;
  logic        src2_busy;

  int n_checks = 0;
  int n_errors = 0;
  bit run_cmp  = 1'b0;

`ifdef RF_ARB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  regfile_wb_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_idx       (req_idx),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .out_write     (out_write),
    .out_dst_idx   (out_dst_idx),
    .out_dst       (out_dst),
    .reserve_valid (reserve_valid),
    .reserve_idx   (reserve_idx),
    .reserve_ready (reserve_ready),
    .chk_src1_idx  (chk_src1_idx),
    .chk_src2_idx  (chk_src2_idx),
    .src1_busy     (src1_busy),
    .src2_busy     (src2_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: last winner, one pending write, set of reserved registers.
  int          m_last;
  bit          m_wr;
  logic [3:0]  m_idx;
  logic [15:0] m_data;
  bit          m_busy [16];

  function automatic int exp_winner();
    for (int k = 1; k <= 3; k++) begin
      int c = (m_last + k) % 3;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin : model
    int w;
    logic [3:0] wi;
    if (reset) begin
      m_last = 2;
      m_wr   = 1'b0;
      m_idx  = '0;
      m_data = '0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      if (SB_EN) begin
        if (m_wr) m_busy[m_idx] = 1'b0;
        if (reserve_valid && reserve_idx != 4'd0 && !m_busy[reserve_idx])
          m_busy[reserve_idx] = 1'b1;
      end
      w = exp_winner();
      m_wr = 1'b0;
      if (w >= 0) begin
        m_last = w;
        wi = req_idx[w*4 +: 4];
        if (wi != 4'd0) begin
          m_wr   = 1'b1;
          m_idx  = wi;
          m_data = req_data[w*16 +: 16];
        end
      end
    end
  end

  always @(negedge clock) begin : compare
    int w;
    logic [2:0] eg;
    if (run_cmp && !reset) begin
      w  = exp_winner();
      eg = (w >= 0) ? 3'(3'b001 << w) : 3'b000;
      chk("req_ready", 32'(req_ready), 32'(eg));
      chk("out_write", 32'(out_write), 32'(m_wr));
      if (m_wr) begin
        chk("out_dst_idx", 32'(out_dst_idx), 32'(m_idx));
        chk("out_dst", 32'(out_dst), 32'(m_data));
      end
      chk("reserve_ready", 32'(reserve_ready), SB_EN ? 32'(!m_busy[reserve_idx]) : 32'd1);
      chk("src1_busy", 32'(src1_busy), SB_EN ? 32'(m_busy[chk_src1_idx]) : 32'd0);
      chk("src2_busy", 32'(src2_busy), SB_EN ? 32'(m_busy[chk_src2_idx]) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic set_req(input int r, input logic [3:0] idx, input logic [15:0] d);
    req_idx[r*4 +: 4]   = idx;
    req_data[r*16 +: 16] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [2:0] got [6];
  int         wcount;

  initial begin
    req_valid     = '0;
    req_idx       = '0;
    req_data      = '0;
    reserve_valid = 1'b0;
    reserve_idx   = '0;
    chk_src1_idx  = 4'd7;
    chk_src2_idx  = 4'd3;
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst out_write", 32'(out_write), 32'd0);
    chk("rst out_dst_idx", 32'(out_dst_idx), 32'd0);
    chk("rst out_dst", 32'(out_dst), 32'd0);
    chk("rst src1_busy", 32'(src1_busy), 32'd0);
    chk("rst reserve_ready", 32'(reserve_ready), 32'd1);
    reset   = 1'b0;
    run_cmp = 1'b1;

    // Single write from requester 1
    set_req(1, 4'd5, 16'hBEEF);
    req_valid = 3'b010;
    mid();
    chk("t1 ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b000;
    mid();
    chk("t1 out_write", 32'(out_write), 32'd1);
    chk("t1 out_dst_idx", 32'(out_dst_idx), 32'd5);
    chk("t1 out_dst", 32'(out_dst), 32'hBEEF);
    tick();
    mid();
    chk("t1 out_write drop", 32'(out_write), 32'd0);
    tick();

    // All three requesters held valid for six cycles
    do_reset();
    for (int r = 0; r < 3; r++) set_req(r, 4'(8 + r), 16'(16'hA000 + r));
    req_valid = 3'b111;
    wcount = 0;
    for (int k = 0; k < 6; k++) begin
      mid();
      got[k] = req_ready;
      if (k > 0) wcount += int'(out_write);
      tick();
    end
    req_valid = 3'b000;
    mid();
    wcount += int'(out_write);
    chk("t2 grant0", 32'(got[0]), 32'h1);
    chk("t2 grant1", 32'(got[1]), 32'h2);
    chk("t2 grant2", 32'(got[2]), 32'h4);
    chk("t2 grant3", 32'(got[3]), 32'h1);
    chk("t2 grant4", 32'(got[4]), 32'h2);
    chk("t2 grant5", 32'(got[5]), 32'h4);
    chk("t2 write run", 32'(wcount), 32'd6);
    tick();
    mid();
    chk("t2 write end", 32'(out_write), 32'd0);
    tick();

    // Index 0 is accepted but not written; next grant moves on
    set_req(0, 4'd0, 16'h1234);
    req_valid = 3'b001;
    mid();
    chk("t3 ready0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b000;
    mid();
    chk("t3 no write", 32'(out_write), 32'd0);
    tick();
    set_req(1, 4'd2, 16'h5555);
    req_valid = 3'b011;
    mid();
    chk("t3 ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b000;
    mid();
    chk("t3 write idx", 32'(out_dst_idx), 32'd2);
    tick();

`ifdef RF_ARB_SCOREBOARD_EN
    chk_src1_idx  = 4'd3;
    reserve_idx   = 4'd3;
    reserve_valid = 1'b1;
    mid();
    chk("sb ready free", 32'(reserve_ready), 32'd1);
    tick();
    reserve_valid = 1'b0;
    mid();
    chk("sb busy set", 32'(src1_busy), 32'd1);
    chk("sb ready busy", 32'(reserve_ready), 32'd0);
    tick();
    set_req(0, 4'd3, 16'h0033);
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    mid();
    chk("sb busy at write", 32'(src1_busy), 32'd1);
    tick();
    mid();
    chk("sb busy cleared", 32'(src1_busy), 32'd0);
    tick();
    set_req(1, 4'd3, 16'h0034);
    req_valid = 3'b010;
    tick();
    req_valid     = 3'b000;
    reserve_valid = 1'b1;
    mid();
    chk("sb same-edge ready", 32'(reserve_ready), 32'd1);
    tick();
    reserve_valid = 1'b0;
    mid();
    chk("sb set wins", 32'(src1_busy), 32'd1);
    tick();
`else
    chk_src1_idx  = 4'd4;
    reserve_idx   = 4'd4;
    reserve_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("nosb src1_busy", 32'(src1_busy), 32'd0);
      chk("nosb reserve_ready", 32'(reserve_ready), 32'd1);
      tick();
    end
    reserve_valid = 1'b0;
`endif

    // Reset while a write to idx 7 is on the port
    chk_src1_idx  = 4'd7;
    reserve_idx   = 4'd7;
    reserve_valid = 1'b1;
    tick();
    reserve_valid = 1'b0;
    set_req(2, 4'd7, 16'h7777);
    req_valid = 3'b100;
    tick();
    req_valid = 3'b000;
    chk("rst2 pre write", 32'(out_write), 32'd1);
    chk("rst2 pre busy", 32'(src1_busy), 32'(SB_EN));
    reset = 1'b1;
    #1;
    chk("rst2 out_write", 32'(out_write), 32'd0);
    chk("rst2 out_dst_idx", 32'(out_dst_idx), 32'd0);
    chk("rst2 out_dst", 32'(out_dst), 32'd0);
    chk("rst2 busy7", 32'(src1_busy), 32'd0);
    tick();
    reset = 1'b0;
    req_valid = 3'b111;
    #1;
    chk("rst2 prio0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b000;
    mid();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between NUM_REQ writeback requesters (ALU, load unit, debug port) using round-robin arbitration with valid/ready handshakes.
Drives the register file's write/index/data inputs from registered outputs, one write per cycle.
Keeps a pending-write scoreboard so the issue stage can stall on read-after-write and write-after-write hazards against registers not yet written.

Parameters:
WORD_WIDTH, 16, data word width; matches the register file.
IDX_WIDTH, 4, register index width; NUM_REGS = 2**IDX_WIDTH.
NUM_REQ, 3, number of writeback requesters (minimum 2).

Ports:
clock  input  1  clock.
reset  input  1  reset, asynchronous, active-high.
req_valid  input  NUM_REQ  per-requester write request.
req_idx  input  NUM_REQ*IDX_WIDTH  destination index; requester i occupies slice i.
req_data  input  NUM_REQ*WORD_WIDTH  write data; requester i occupies slice i.
req_ready  output  NUM_REQ  grant; transfer occurs when valid and ready are both 1.
out_write  output  1  write enable to the register file.
out_dst_idx  output  IDX_WIDTH  destination index to the register file.
out_dst  output  WORD_WIDTH  write data to the register file.
reserve_valid  input  1  issue stage reserves a destination register.
reserve_idx  input  IDX_WIDTH  register being reserved.
reserve_ready  output  1  reservation can be accepted.
chk_src1_idx  input  IDX_WIDTH  source 1 index to check for a pending write.
chk_src2_idx  input  IDX_WIDTH  source 2 index to check for a pending write.
src1_busy  output  1  source 1 has a pending write.
src2_busy  output  1  source 2 has a pending write.

Behaviour:
- Reset values: out_write=0, out_dst_idx=0, out_dst=0, busy[]=all 0, rr_ptr=NUM_REQ-1 (requester 0 has highest priority first). Reset asserted mid-operation drops any registered write; a requester that was granted before reset is not retried.
- Arbitration (combinational):
  - Search order starts at rr_ptr+1 modulo NUM_REQ.
  - The first requester with valid=1 wins; req_ready is one-hot on the winner and all zero when no requester is valid.
  - req_ready never depends on any other signal.
- rr_ptr updates to the winner index only on a transfer and holds otherwise.
- Requester rules: req_valid, req_idx and req_data stay stable until the transfer. Deasserting valid before the transfer is a protocol violation.
- Write port latency is 1 cycle. On the edge after a transfer:
  - out_write=1, with out_dst_idx and out_dst set to the winner's slices.
  - out_write is high for exactly one cycle per transfer.
  - Back-to-back transfers give a continuous out_write stream with a new index and data every cycle.
- Index 0: the transfer is accepted (ready=1, rr_ptr advances) but out_write stays 0 and the data is discarded.
- Scoreboard: busy[NUM_REGS] bits; busy[0] is constant 0.
  - Set: on an edge where reserve_valid, reserve_ready and reserve_idx!=0 are all true.
  - Clear: busy[out_dst_idx] clears on an edge where out_write=1. This is the same edge on which the register file stores the data, so busy=0 means an asynchronous read returns the new value.
  - Set and clear of the same index on the same edge: set wins.
  - reserve_ready = !busy[reserve_idx] (always 1 for index 0), which blocks write-after-write hazards. A reservation attempted with reserve_ready=0 is ignored.
  - src1_busy = busy[chk_src1_idx]; src2_busy = busy[chk_src2_idx]. Both are combinational and reflect the current busy state only, with no bypass.
- A writeback to a register that is not busy is legal: it is written and busy is unaffected.

Optional Feature:
Macro RF_ARB_SCOREBOARD_EN.
- Defined: the scoreboard behaves as described above.
- Undefined: no busy storage; src1_busy=src2_busy=0 and reserve_ready=1 constant; reserve inputs are ignored. The arbiter and write-port path are unchanged.

Decomposition:
- Package regfile_pkg holds: WORD_WIDTH/IDX_WIDTH defaults, NUM_REGS, and requester ID constants REQ_ALU=0, REQ_LOAD=1, REQ_DEBUG=2.
- Sub-module rr_arbiter (parameter N) holds: request vector in, one-hot grant out, the advance strobe, and rr_ptr with its reset state.
- The top level holds the output registers, the index-0 filter and the scoreboard.

Test Plan:
- Reset, then requester 1 alone writes idx 5, data 0xBEEF -> ready[1]=1 the same cycle; the next cycle has out_write=1, out_dst_idx=5, out_dst=0xBEEF; the cycle after has out_write=0.
- All three requesters held valid for 6 cycles -> grant order 0,1,2,0,1,2 with out_write high for 6 consecutive cycles.
- Requester 0 writes idx 0, data 0x1234 -> ready[0]=1, out_write stays 0, and the next grant goes to requester 1 when it is valid.
- Reserve idx 3, then chk_src1_idx=3 -> src1_busy=1 and reserve_ready=0 for idx 3. A writeback to idx 3 then drops src1_busy on the edge where out_write=1. A same-edge re-reserve of idx 3 keeps busy=1.
- Reset asserted while out_write=1 for idx 7 with busy[7]=1 -> outputs go to 0 immediately, busy[7]=0, and rr_ptr returns so requester 0 has highest priority.
- Build without RF_ARB_SCOREBOARD_EN: reserve idx 4 -> src1_busy=0 and reserve_ready=1 throughout.
